// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and widths for the pipeline stall/flush controller.
// FSM states are 2-bit constants so legacy netlists can decode them directly.
package mips_pipe_pkg;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_WAIT = 2'd1;
    localparam logic [1:0] ST_EXC     = 2'd2;
    localparam int         T_W        = 2;
    localparam int         CNT_W      = 6;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard info and mult/div/exception
// requests in, stall/flush controls out. st_dbg exposes the FSM state.
interface pipeline_hazard_ctrl_if;
    import mips_pipe_pkg::*;

    logic [4:0]     IDrs;
    logic [4:0]     IDrt;
    logic           IDuse_rs;
    logic           IDuse_rt;
    logic [T_W-1:0] IDt_use_rs;
    logic [T_W-1:0] IDt_use_rt;
    logic           EXregwrite;
    logic [4:0]     EXdest;
    logic [T_W-1:0] EXt_new;
    logic           MEMregwrite;
    logic [4:0]     MEMdest;
    logic [T_W-1:0] MEMt_new;
    logic           EXmd_start;
    logic           EXmd_div;
    logic           exc_req;

    logic           PCstall;
    logic           IFIDstall;
    logic           IFIDflush;
    logic           IDEXstall;
    logic           IDEXflush;
    logic           EXMEMflush;
    logic           md_busy;
    logic           md_done;
    logic           md_abort;
    logic           pc_sel_exc;
    logic [1:0]     st_dbg;

    // Levels only, no handshake: every input is sampled every cycle and every
    // output is valid in the same cycle (combinational from state and inputs).
    modport master (
        output IDrs, IDrt, IDuse_rs, IDuse_rt, IDt_use_rs, IDt_use_rt,
        output EXregwrite, EXdest, EXt_new, MEMregwrite, MEMdest, MEMt_new,
        output EXmd_start, EXmd_div, exc_req,
        input  PCstall, IFIDstall, IFIDflush, IDEXstall, IDEXflush, EXMEMflush,
        input  md_busy, md_done, md_abort, pc_sel_exc, st_dbg
    );

    modport slave (
        input  IDrs, IDrt, IDuse_rs, IDuse_rt, IDt_use_rs, IDt_use_rt,
        input  EXregwrite, EXdest, EXt_new, MEMregwrite, MEMdest, MEMt_new,
        input  EXmd_start, EXmd_div, exc_req,
        output PCstall, IFIDstall, IFIDflush, IDEXstall, IDEXflush, EXMEMflush,
        output md_busy, md_done, md_abort, pc_sel_exc, st_dbg
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational read-after-write hazard term: a source is hazardous when a
// producer in EX or MEM will not have its result forwardable in time.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic [4:0]     i_rs,
    input  logic [4:0]     i_rt,
    input  logic           i_use_rs,
    input  logic           i_use_rt,
    input  logic [T_W-1:0] i_t_use_rs,
    input  logic [T_W-1:0] i_t_use_rt,
    input  logic           i_ex_we,
    input  logic [4:0]     i_ex_dest,
    input  logic [T_W-1:0] i_ex_t_new,
    input  logic           i_mem_we,
    input  logic [4:0]     i_mem_dest,
    input  logic [T_W-1:0] i_mem_t_new,
    output logic           o_hazard
);
    logic w_haz_rs;
    logic w_haz_rt;

    // $0 is hardwired zero, so it can never be a true dependency.
    assign w_haz_rs = i_use_rs && (i_rs != 5'd0) &&
                      ((i_ex_we  && (i_ex_dest  == i_rs) && (i_ex_t_new  > i_t_use_rs)) ||
                       (i_mem_we && (i_mem_dest == i_rs) && (i_mem_t_new > i_t_use_rs)));

    assign w_haz_rt = i_use_rt && (i_rt != 5'd0) &&
                      ((i_ex_we  && (i_ex_dest  == i_rt) && (i_ex_t_new  > i_t_use_rt)) ||
                       (i_mem_we && (i_mem_dest == i_rt) && (i_mem_t_new > i_t_use_rt)));

    assign o_hazard = w_haz_rs || w_haz_rt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use hazards, multi-cycle mult/div hold
// and exception/eret front-end flush for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    logic [1:0]       r_st;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_st_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hazard;
    logic             w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
    logic             w_idex_flush, w_exmem_flush, w_md_busy, w_md_done;
    logic             w_md_abort, w_pc_sel_exc;

    hazard_detect u_hazard_detect (
        .i_rs        (bus.IDrs),
        .i_rt        (bus.IDrt),
        .i_use_rs    (bus.IDuse_rs),
        .i_use_rt    (bus.IDuse_rt),
        .i_t_use_rs  (bus.IDt_use_rs),
        .i_t_use_rt  (bus.IDt_use_rt),
        .i_ex_we     (bus.EXregwrite),
        .i_ex_dest   (bus.EXdest),
        .i_ex_t_new  (bus.EXt_new),
        .i_mem_we    (bus.MEMregwrite),
        .i_mem_dest  (bus.MEMdest),
        .i_mem_t_new (bus.MEMt_new),
        .o_hazard    (w_hazard)
    );

    always_comb begin
        w_st_nxt      = r_st;
        w_cnt_nxt     = r_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_md_busy     = 1'b0;
        w_md_done     = 1'b0;
        w_md_abort    = 1'b0;
        w_pc_sel_exc  = 1'b0;
        case (r_st)
            ST_RUN: begin
                if (bus.exc_req) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_pc_sel_exc  = 1'b1;
                    w_st_nxt      = ST_EXC;
                end else if (bus.EXmd_start) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_md_busy     = 1'b1;
                    w_cnt_nxt     = bus.EXmd_div ? DIV_LOAD : MUL_LOAD;
                    w_st_nxt      = ST_MD_WAIT;
                end else if (w_hazard) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_flush  = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (bus.exc_req) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_pc_sel_exc  = 1'b1;
                    w_md_abort    = 1'b1;
                    w_cnt_nxt     = '0;
                    w_st_nxt      = ST_EXC;
                end else if (r_cnt != '0) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_md_busy     = 1'b1;
                    w_cnt_nxt     = r_cnt - 1'b1;
                end else begin
                    // Last occupancy cycle: release so the next op enters EX.
                    w_md_busy     = 1'b1;
                    w_md_done     = 1'b1;
                    w_st_nxt      = ST_RUN;
                end
            end
            ST_EXC: begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_st_nxt     = ST_RUN;
            end
            default: w_st_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st  <= ST_RUN;
            r_cnt <= '0;
        end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign bus.PCstall    = reset && w_pc_stall;
    assign bus.IFIDstall  = reset && w_ifid_stall;
    assign bus.IFIDflush  = reset && w_ifid_flush;
    assign bus.IDEXstall  = reset && w_idex_stall;
    assign bus.IDEXflush  = reset && w_idex_flush;
    assign bus.EXMEMflush = reset && w_exmem_flush;
    assign bus.md_busy    = reset && w_md_busy;
    assign bus.md_done    = reset && w_md_done;
    assign bus.md_abort   = reset && w_md_abort;
    assign bus.pc_sel_exc = reset && w_pc_sel_exc;
    assign bus.st_dbg     = reset ? r_st : ST_RUN;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each cycle's expected state and
// control vector is queued by the driver and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;
  import mips_pipe_pkg::*;

  // Output vector bit order: {st[1:0], PCstall, IFIDstall, IFIDflush, IDEXstall,
  // IDEXflush, EXMEMflush, md_busy, md_done, md_abort, pc_sel_exc}
  localparam logic [9:0] E_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] E_HAZ   = 10'b11_0010_0000;
  localparam logic [9:0] E_EXC   = 10'b00_1011_0001;
  localparam logic [9:0] E_MDS   = 10'b11_0101_1000;
  localparam logic [9:0] E_DONE  = 10'b00_0000_1100;
  localparam logic [9:0] E_ABORT = 10'b00_1011_0011;
  localparam logic [9:0] E_EXCST = 10'b00_1010_0000;

  logic clk;
  logic reset;
  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] exp_v;
      logic [11:0] act_v;
      string       tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_v = {bus.st_dbg, bus.PCstall, bus.IFIDstall, bus.IFIDflush, bus.IDEXstall,
               bus.IDEXflush, bus.EXMEMflush, bus.md_busy, bus.md_done, bus.md_abort,
               bus.pc_sel_exc};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL %s: got st=%0d ctl=%b, expected st=%0d ctl=%b at %0t",
                 tag, act_v[11:10], act_v[9:0], exp_v[11:10], exp_v[9:0], $time);
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus.IDrs = 5'd0;        bus.IDrt = 5'd0;
    bus.IDuse_rs = 1'b0;    bus.IDuse_rt = 1'b0;
    bus.IDt_use_rs = 2'd0;  bus.IDt_use_rt = 2'd0;
    bus.EXregwrite = 1'b0;  bus.EXdest = 5'd0;  bus.EXt_new = 2'd0;
    bus.MEMregwrite = 1'b0; bus.MEMdest = 5'd0; bus.MEMt_new = 2'd0;
    bus.EXmd_start = 1'b0;  bus.EXmd_div = 1'b0;
    bus.exc_req = 1'b0;
  endtask

  task automatic cycle(input logic [1:0] st, input logic [9:0] ctl, input string tag);
    exp_q.push_back({st, ctl});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // reset state, even with requests present
    cycle(ST_RUN, E_NONE, "reset_idle");
    bus.exc_req = 1'b1; bus.EXmd_start = 1'b1;
    cycle(ST_RUN, E_NONE, "reset_masks");
    clear_inputs();
    reset = 1'b1;
    cycle(ST_RUN, E_NONE, "run_idle");

    // load-use on rs: lw $5 in EX, addu reads $5 next cycle
    bus.IDrs = 5'd5; bus.IDuse_rs = 1'b1; bus.IDt_use_rs = 2'd1;
    bus.EXregwrite = 1'b1; bus.EXdest = 5'd5; bus.EXt_new = 2'd2;
    cycle(ST_RUN, E_HAZ, "loaduse_ex");
    bus.EXregwrite = 1'b0; bus.EXdest = 5'd0; bus.EXt_new = 2'd0;
    bus.MEMregwrite = 1'b1; bus.MEMdest = 5'd5; bus.MEMt_new = 2'd1;
    cycle(ST_RUN, E_NONE, "loaduse_mem_ok");

    // rt from MEM still too late; t_new == t_use is fine; unused source ignored
    clear_inputs();
    bus.IDrt = 5'd7; bus.IDuse_rt = 1'b1; bus.IDt_use_rt = 2'd0;
    bus.MEMregwrite = 1'b1; bus.MEMdest = 5'd7; bus.MEMt_new = 2'd2;
    cycle(ST_RUN, E_HAZ, "rt_mem_haz");
    bus.IDt_use_rt = 2'd2;
    cycle(ST_RUN, E_NONE, "rt_equal_ok");
    bus.IDt_use_rt = 2'd0; bus.IDuse_rt = 1'b0;
    cycle(ST_RUN, E_NONE, "rt_unused");
    bus.IDuse_rt = 1'b1; bus.MEMregwrite = 1'b0;
    cycle(ST_RUN, E_NONE, "rt_no_write");

    // register $0 never hazards
    clear_inputs();
    bus.IDrs = 5'd0; bus.IDuse_rs = 1'b1; bus.IDt_use_rs = 2'd0;
    bus.EXregwrite = 1'b1; bus.EXdest = 5'd0; bus.EXt_new = 2'd3;
    cycle(ST_RUN, E_NONE, "reg0_no_haz");

    // div: 32-cycle occupancy, hazard during the hold is not evaluated
    clear_inputs();
    bus.EXmd_start = 1'b1; bus.EXmd_div = 1'b1;
    cycle(ST_RUN, E_MDS, "div_start");
    bus.IDrs = 5'd9; bus.IDuse_rs = 1'b1; bus.IDt_use_rs = 2'd0;
    bus.EXregwrite = 1'b1; bus.EXdest = 5'd9; bus.EXt_new = 2'd1;
    for (int i = 0; i < 30; i++) cycle(ST_MD_WAIT, E_MDS, "div_hold");
    cycle(ST_MD_WAIT, E_DONE, "div_done");
    bus.EXmd_start = 1'b0; bus.EXmd_div = 1'b0;
    cycle(ST_RUN, E_HAZ, "post_md_haz");
    clear_inputs();
    cycle(ST_RUN, E_NONE, "post_md_idle");

    // mult aborted by exception in its second cycle
    bus.EXmd_start = 1'b1;
    cycle(ST_RUN, E_MDS, "mul_start");
    bus.exc_req = 1'b1;
    cycle(ST_MD_WAIT, E_ABORT, "mul_abort");
    cycle(ST_EXC, E_EXCST, "exc_after_abort");
    clear_inputs();
    cycle(ST_RUN, E_NONE, "run_after_abort");

    // exception beats hazard and md start in RUN
    bus.IDrs = 5'd3; bus.IDuse_rs = 1'b1; bus.IDt_use_rs = 2'd0;
    bus.EXregwrite = 1'b1; bus.EXdest = 5'd3; bus.EXt_new = 2'd2;
    bus.exc_req = 1'b1;
    cycle(ST_RUN, E_EXC, "exc_over_haz");
    bus.exc_req = 1'b0;
    cycle(ST_EXC, E_EXCST, "exc_state_haz");
    cycle(ST_RUN, E_HAZ, "haz_after_exc");
    clear_inputs();
    bus.exc_req = 1'b1; bus.EXmd_start = 1'b1;
    cycle(ST_RUN, E_EXC, "exc_over_md");
    clear_inputs();
    cycle(ST_EXC, E_EXCST, "exc_state");
    cycle(ST_RUN, E_NONE, "run_after_exc");

    // reset during mult hold, then a clean 4-cycle mult
    bus.EXmd_start = 1'b1;
    cycle(ST_RUN, E_MDS, "mul_pre_rst");
    cycle(ST_MD_WAIT, E_MDS, "mul_hold_pre_rst");
    reset = 1'b0;
    cycle(ST_RUN, E_NONE, "rst_mid_op");
    bus.exc_req = 1'b1;
    cycle(ST_RUN, E_NONE, "rst_mid_hold");
    bus.exc_req = 1'b0;
    reset = 1'b1;
    cycle(ST_RUN, E_MDS, "mul2_start");
    cycle(ST_MD_WAIT, E_MDS, "mul2_hold1");
    cycle(ST_MD_WAIT, E_MDS, "mul2_hold2");
    cycle(ST_MD_WAIT, E_DONE, "mul2_done");
    clear_inputs();
    cycle(ST_RUN, E_NONE, "mul2_after");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
